// File: rtl/flash_op_sequencer.sv
// Turns high-level flash operations (erase / program / read) into the dword
// command stream: write-enable, command + address (+ data), then status polling.
module flash_op_sequencer #(
  parameter int PROG_WORDS = 4,
  parameter int POLL_MAX   = 1000000,
  parameter int POLL_GAP   = 16
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [23:0] op_addr,
  input  logic [31:0] wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic        done,
  output logic [1:0]  err_code,
  output logic [63:0] rdata,
  output logic        dw_wr,
  output logic [31:0] dw_data,
  input  logic        dw_busy,
  input  logic        dw_error,
  input  logic [63:0] dw_readout
);

  localparam int PCW = ($clog2(POLL_MAX + 1) > 20) ? $clog2(POLL_MAX + 1) : 20;
  localparam int GCW = ($clog2(POLL_GAP + 1) > 1) ? $clog2(POLL_GAP + 1) : 1;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_ERASE = 8'hD8;
  localparam logic [7:0] CMD_PROG  = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] PROG_LEN  = 8'(1 + PROG_WORDS);

  localparam logic [1:0] OP_ERASE   = 2'd0;
  localparam logic [1:0] OP_PROGRAM = 2'd1;
  localparam logic [1:0] OP_READ    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef enum logic [3:0] {
    WAIT_IF, IDLE, WREN_HDR, WREN_WAIT, OP_HDR, OP_ADDR, OP_DATA,
    OP_WAIT, POLL_GAP_ST, POLL_HDR, POLL_WAIT, POLL_CHECK, FINISH
  } state_t;

  state_t          state;
  logic [1:0]      code_reg;
  logic [23:0]     addr_reg;
  logic [PCW-1:0]  poll_cnt;
  logic [GCW-1:0]  gap_cnt;
  logic [3:0]      word_cnt;
  logic [1:0]      err_reg;
  logic [63:0]     rdata_reg;
  logic [7:0]      op_cmd;
  logic [7:0]      op_len;

  function automatic logic [31:0] header(input logic [7:0] len, input logic [7:0] cmd);
    return {15'b0, 1'b0, len, cmd};
  endfunction

  always_comb begin
    op_cmd = CMD_READ;
    op_len = 8'd1;
    case (code_reg)
      OP_ERASE:   op_cmd = CMD_ERASE;
      OP_PROGRAM: begin
        op_cmd = CMD_PROG;
        op_len = PROG_LEN;
      end
      default: ;
    endcase
  end

  // Words are driven in the cycle the state owns them; headers wait for an idle interface.
  always_comb begin
    dw_wr   = 1'b0;
    dw_data = '0;
    if (!reset) begin
      case (state)
        WREN_HDR: if (!dw_busy) begin
          dw_wr   = 1'b1;
          dw_data = header(8'd0, CMD_WREN);
        end
        OP_HDR: if (!dw_busy) begin
          dw_wr   = 1'b1;
          dw_data = header(op_len, op_cmd);
        end
        OP_ADDR: begin
          dw_wr   = 1'b1;
          dw_data = {8'h00, addr_reg};
        end
        OP_DATA: if (wdata_valid) begin
          dw_wr   = 1'b1;
          dw_data = wdata;
        end
        POLL_HDR: if (!dw_busy) begin
          dw_wr   = 1'b1;
          dw_data = header(8'd0, CMD_RDSR);
        end
        default: ;
      endcase
    end
  end

  assign op_ready    = !reset && (state == IDLE);
  assign wdata_ready = !reset && (state == OP_DATA);
  assign done        = !reset && (state == FINISH);
  assign err_code    = err_reg;
  assign rdata       = rdata_reg;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= WAIT_IF;
      code_reg  <= '0;
      addr_reg  <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      word_cnt  <= '0;
      err_reg   <= '0;
      rdata_reg <= '0;
    end else begin
      case (state)
        WAIT_IF: if (!dw_busy) state <= IDLE;
        IDLE: if (op_valid) begin
          code_reg <= op_code;
          addr_reg <= op_addr;
          err_reg  <= 2'd0;
          poll_cnt <= '0;
          word_cnt <= '0;
          if (op_code == OP_ILLEGAL) begin
            err_reg <= 2'd3;
            state   <= FINISH;
          end else if (op_code == OP_READ) begin
            state <= OP_HDR;
          end else begin
            state <= WREN_HDR;
          end
        end
        WREN_HDR: if (!dw_busy) state <= WREN_WAIT;
        WREN_WAIT: if (!dw_busy) begin
          if (dw_error) begin
            err_reg <= 2'd1;
            state   <= FINISH;
          end else begin
            state <= OP_HDR;
          end
        end
        OP_HDR: if (!dw_busy) state <= OP_ADDR;
        OP_ADDR: state <= (code_reg == OP_PROGRAM) ? OP_DATA : OP_WAIT;
        OP_DATA: if (wdata_valid) begin
          if (word_cnt == 4'(PROG_WORDS - 1)) state <= OP_WAIT;
          else word_cnt <= word_cnt + 4'd1;
        end
        OP_WAIT: if (!dw_busy) begin
          if (dw_error) begin
            err_reg <= 2'd1;
            state   <= FINISH;
          end else if (code_reg == OP_READ) begin
            rdata_reg <= dw_readout;
            state     <= FINISH;
          end else begin
            gap_cnt <= '0;
            state   <= POLL_GAP_ST;
          end
        end
        POLL_GAP_ST: begin
          if (int'(gap_cnt) + 1 >= POLL_GAP) state <= POLL_HDR;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        POLL_HDR: if (!dw_busy) state <= POLL_WAIT;
        POLL_WAIT: if (!dw_busy) begin
          if (dw_error) begin
            err_reg <= 2'd1;
            state   <= FINISH;
          end else begin
            state <= POLL_CHECK;
          end
        end
        // WIP clear wins over the timeout on the final allowed poll.
        POLL_CHECK: begin
          if (!dw_readout[0]) begin
            state <= FINISH;
          end else if (int'(poll_cnt) + 1 >= POLL_MAX) begin
            poll_cnt <= PCW'(POLL_MAX);
            err_reg  <= 2'd2;
            state    <= FINISH;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
            gap_cnt  <= '0;
            state    <= POLL_GAP_ST;
          end
        end
        FINISH: state <= IDLE;
        default: state <= WAIT_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Randomized bench for flash_op_sequencer: a behavioural dword-interface responder
// plus an operation-level expectation model of the emitted word stream.
module tb_flash_op_sequencer;
  localparam int PW   = 4;
  localparam int PMAX = 3;
  localparam int PGAP = 3;

  logic        clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = '0;
  logic [23:0] op_addr = '0;
  logic [31:0] wdata = '0;
  logic        wdata_valid = 1'b0;
  logic        op_ready, wdata_ready, done, dw_wr;
  logic [1:0]  err_code;
  logic [63:0] rdata;
  logic [31:0] dw_data;
  logic        dw_busy = 1'b1;
  logic        dw_error = 1'b0;
  logic [63:0] dw_readout = '0;

  always #5 clk_in = ~clk_in;

  flash_op_sequencer #(.PROG_WORDS(PW), .POLL_MAX(PMAX), .POLL_GAP(PGAP)) dut (
    .clk_in(clk_in), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_addr(op_addr), .wdata(wdata), .wdata_valid(wdata_valid),
    .wdata_ready(wdata_ready), .done(done), .err_code(err_code), .rdata(rdata),
    .dw_wr(dw_wr), .dw_data(dw_data), .dw_busy(dw_busy), .dw_error(dw_error),
    .dw_readout(dw_readout)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Interface responder state
  int          delay_cyc = 5;
  int          err_at = -1;
  int          txn_count = 0;
  int          txn_cur = 0;
  int          tail = 0;
  logic [7:0]  rem = '0;
  logic [7:0]  cmd = '0;
  logic [7:0]  st;
  logic [7:0]  status_q[$];
  logic [63:0] read_val = '0;
  logic [31:0] obs_q[$];
  logic        s_wr = 1'b0;
  logic [31:0] s_data = '0;
  logic [63:0] exp_rdata = '0;

  initial forever begin
    @(negedge clk_in);
    #2;
    s_wr   = dw_wr;
    s_data = dw_data;
    if (dw_wr === 1'b1) begin
      obs_q.push_back(dw_data);
      if (rem == 8'd0) check_eq("hdr_while_busy", {63'h0, dw_busy}, 64'h0);
    end
  end

  // Busy rises after a header and drops delay_cyc cycles after the last word.
  always @(posedge clk_in) begin
    if (reset) begin
      rem      <= '0;
      dw_busy  <= 1'b1;
      tail     <= 3;
      dw_error <= 1'b0;
    end else if (s_wr) begin
      if (rem == 8'd0) begin
        rem       <= s_data[15:8];
        cmd       <= s_data[7:0];
        dw_busy   <= 1'b1;
        dw_error  <= 1'b0;
        txn_cur   <= txn_count;
        txn_count <= txn_count + 1;
        tail      <= delay_cyc;
      end else begin
        rem <= rem - 8'd1;
        if (rem == 8'd1) tail <= delay_cyc;
      end
    end else if (dw_busy && rem == 8'd0) begin
      if (tail <= 1) begin
        dw_busy  <= 1'b0;
        dw_error <= (txn_cur == err_at);
        if (cmd == 8'h05) begin
          st = (status_q.size() > 0) ? status_q.pop_front() : 8'h00;
          dw_readout <= {56'h0, st};
        end else if (cmd == 8'h03) begin
          dw_readout <= read_val;
        end
      end else begin
        tail <= tail - 1;
      end
    end
  end

  task automatic wait_ready(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      #1;
      if (op_ready) begin
        ok = 1;
        break;
      end
    end
    check_eq(tag, {63'h0, ok}, 64'h1);
  endtask

  task automatic run_op(input logic [1:0] code, input logic [23:0] addr, input int e_at,
                        input int nstat, input bit stuck, input bit toggle, input bit seq_data,
                        input int dly, input logic [63:0] rv);
    logic [31:0] exp_q[$];
    logic [31:0] wq[$];
    logic [7:0]  stat[$];
    int exp_err = 0;
    int cyc = 0;
    bit got_done = 0;
    bit tog = 1;
    int n;
    for (int i = 0; i < nstat; i++)
      stat.push_back(stuck ? 8'h01 : ((i == nstat - 1) ? 8'h00 : 8'h03));
    for (int i = 0; i < PW; i++)
      wq.push_back(seq_data ? 32'hA0 + 32'(i) : $urandom);
    case (code)
      2'd3: exp_err = 3;
      2'd2: begin
        exp_q.push_back(32'h0000_0103);
        exp_q.push_back({8'h00, addr});
        if (e_at == 0) exp_err = 1;
        else exp_rdata = rv;
      end
      default: begin
        exp_q.push_back(32'h0000_0006);
        if (e_at == 0) exp_err = 1;
        else begin
          exp_q.push_back(code == 2'd0 ? 32'h0000_01D8 : 32'((PW + 1) * 256 + 2));
          exp_q.push_back({8'h00, addr});
          if (code == 2'd1) foreach (wq[i]) exp_q.push_back(wq[i]);
          if (e_at == 1) exp_err = 1;
          else begin
            for (int i = 0; i < PMAX; i++) begin
              exp_q.push_back(32'h0000_0005);
              if (e_at == i + 2) begin exp_err = 1; break; end
              if (i >= stat.size() || stat[i][0] == 1'b0) break;
              if (i + 1 == PMAX) begin exp_err = 2; break; end
            end
          end
        end
      end
    endcase

    wait_ready("ready_before_op");
    status_q  = stat;
    read_val  = rv;
    delay_cyc = dly;
    err_at    = (e_at >= 0) ? txn_count + e_at : -1;
    obs_q.delete();
    op_valid = 1'b1;
    op_code  = code;
    op_addr  = addr;
    for (cyc = 1; cyc <= 600; cyc++) begin
      @(negedge clk_in);
      #1;
      op_valid = 1'b0;
      op_code  = 2'($urandom);
      op_addr  = 24'($urandom);
      if (cyc == 1) check_eq("err_clear_on_accept", {62'h0, err_code}, (code == 2'd3) ? 64'd3 : 64'd0);
      if (wdata_ready && !wdata_valid) check_eq("stall_wr", {63'h0, dw_wr}, 64'h0);
      if (done) begin
        got_done = 1;
        break;
      end
      wdata_valid = toggle ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      wdata = (wq.size() > 0) ? wq[0] : $urandom;
      if (wdata_valid && wdata_ready && wq.size() > 0) void'(wq.pop_front());
    end
    check_eq("done_seen", {63'h0, got_done}, 64'h1);
    if (code == 2'd3) check_eq("illegal_done_latency", 64'(cyc), 64'd1);
    check_eq("err_code", {62'h0, err_code}, 64'(exp_err));
    check_eq("rdata", rdata, exp_rdata);
    check_eq("word_count", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq($sformatf("word%0d", i), {32'h0, obs_q[i]}, {32'h0, exp_q[i]});
    @(negedge clk_in);
    #1;
    check_eq("done_one_cycle", {63'h0, done}, 64'h0);
    check_eq("ready_after_done", {63'h0, op_ready}, 64'h1);
    $display("op code=%0d addr=%06h err_at=%0d words=%0d err=%0d cycles=%0d",
             code, addr, e_at, obs_q.size(), err_code, cyc);
  endtask

  task automatic reset_mid_op();
    int taken = 0;
    bit ok = 0;
    wait_ready("ready_before_reset_op");
    err_at    = -1;
    delay_cyc = 5;
    obs_q.delete();
    op_valid = 1'b1;
    op_code  = 2'd1;
    op_addr  = 24'h000200;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      #1;
      op_valid = 1'b0;
      wdata_valid = 1'b1;
      wdata = $urandom;
      if (wdata_ready) taken++;
      if (taken == 3) begin
        ok = 1;
        break;
      end
    end
    check_eq("reached_op_data", {63'h0, ok}, 64'h1);
    reset = 1'b1;
    #1;
    check_eq("rst_cycle_no_wr", {63'h0, dw_wr}, 64'h0);
    @(negedge clk_in);
    #1;
    reset = 1'b0;
    wdata_valid = 1'b0;
    exp_rdata = '0;
    #1;
    check_eq("rst_op_ready", {63'h0, op_ready}, 64'h0);
    check_eq("rst_wdata_ready", {63'h0, wdata_ready}, 64'h0);
    check_eq("rst_done", {63'h0, done}, 64'h0);
    check_eq("rst_err_code", {62'h0, err_code}, 64'h0);
    check_eq("rst_rdata", rdata, 64'h0);
    check_eq("rst_dw_wr", {63'h0, dw_wr}, 64'h0);
    check_eq("rst_dw_data", {32'h0, dw_data}, 64'h0);
    wait_ready("rst_ready_after_busy");
    check_eq("rst_busy_low_at_ready", {63'h0, dw_busy}, 64'h0);
    $display("op reset during OP_DATA after %0d words", taken);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    #1;
    check_eq("reset_op_ready", {63'h0, op_ready}, 64'h0);
    check_eq("reset_done", {63'h0, done}, 64'h0);
    check_eq("reset_err_code", {62'h0, err_code}, 64'h0);
    check_eq("reset_rdata", rdata, 64'h0);
    check_eq("reset_dw_wr", {63'h0, dw_wr}, 64'h0);
    check_eq("reset_dw_data", {32'h0, dw_data}, 64'h0);
    reset = 1'b0;
    @(negedge clk_in);
    #1;
    check_eq("wait_if_while_busy", {63'h0, op_ready}, 64'h0);

    run_op(2'd0, 24'h012000, -1, 3, 0, 0, 0, 5, 64'h0);
    run_op(2'd1, 24'h000100, -1, 1, 0, 1, 1, 5, 64'h0);
    run_op(2'd2, 24'h000000, -1, 0, 0, 0, 0, 5, 64'h0123456789ABCDEF);
    run_op(2'd0, 24'h034000, -1, 6, 1, 0, 0, 4, 64'h0);
    run_op(2'd1, 24'h000400, 0, 2, 0, 1, 1, 5, 64'h0);
    run_op(2'd3, 24'h000000, -1, 0, 0, 0, 0, 5, 64'h0);
    reset_mid_op();

    for (int k = 0; k < 40; k++) begin
      run_op(2'($urandom_range(0, 3)), 24'($urandom),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
             int'($urandom_range(1, 4)), 1'($urandom_range(0, 1) & $urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, int'($urandom_range(1, 6)),
             {$urandom, $urandom});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
